// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default constants for mem_port_arbiter
package mem_port_arbiter_pkg;

  localparam int LDTAG_W_DEF     = 4;
  localparam int OUTST_DEPTH_DEF = 4;
  localparam int STARVE_LIM_DEF  = 8;

  // Tag field sized for the widest supported LDTAG_W; narrower tags are zero-extended.
  localparam int LDTAG_MAX_W = 16;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_LOAD  = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_LOAD,
    GNT_STORE,
    GNT_FETCH
  } gnt_e;

  typedef struct packed {
    src_e                   src;
    logic [LDTAG_MAX_W-1:0] tag;
    logic                   drop;
  } rd_entry_t;

endpackage

// File: rtl/mem_port_arbiter_rd_order_fifo.sv
// rtl/mem_port_arbiter_rd_order_fifo.sv - in-order read tracking FIFO with fetch drop marking
module rd_order_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTST_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  rd_entry_t push_entry_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output logic      full_o,
  output logic      empty_o,
  output rd_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  rd_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // Marking stale slots is harmless: a push always rewrites the whole entry.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i && mem_q[i].src == SRC_FETCH) mem_q[i].drop <= 1'b1;
      end
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load/store arbiter onto one memory port with in-order read return
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LDTAG_W     = LDTAG_W_DEF,
  parameter int OUTST_DEPTH = OUTST_DEPTH_DEF,
  parameter int STARVE_LIM  = STARVE_LIM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_valid,
  output logic               if_req_ready,
  input  logic [31:0]        if_req_addr,
  output logic               if_resp_valid,
  input  logic               if_resp_ready,
  output logic [31:0]        if_resp_inst,
  input  logic               if_flush,
  input  logic               ld_req_valid,
  output logic               ld_req_ready,
  input  logic [31:0]        ld_req_addr,
  input  logic [LDTAG_W-1:0] ld_req_tag,
  output logic               ld_resp_valid,
  input  logic               ld_resp_ready,
  output logic [31:0]        ld_resp_data,
  output logic [LDTAG_W-1:0] ld_resp_tag,
  input  logic               st_req_valid,
  output logic               st_req_ready,
  input  logic [31:0]        st_req_addr,
  input  logic [31:0]        st_req_wdata,
  input  logic [3:0]         st_req_wstrb,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [31:0]        mem_req_addr,
  output logic [31:0]        mem_req_wdata,
  output logic [3:0]         mem_req_wstrb,
  input  logic               mem_resp_valid,
  output logic               mem_resp_ready,
  input  logic [31:0]        mem_resp_data
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  gnt_e          gnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  rd_entry_t     push_entry;
  rd_entry_t     head;
  logic          ld_elig;
  logic          st_elig;
  logic          if_elig;
  logic          if_hs;
  logic          unused_tag_bits;

  assign ld_elig = ld_req_valid && !fifo_full;
  assign st_elig = st_req_valid;
  assign if_elig = if_req_valid && !fifo_full && !if_flush;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (if_elig && starve_q == SW'(STARVE_LIM)) gnt = GNT_FETCH;
      else if (ld_elig)                          gnt = GNT_LOAD;
      else if (st_elig)                          gnt = GNT_STORE;
      else if (if_elig)                          gnt = GNT_FETCH;
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    ld_req_ready  = 1'b0;
    st_req_ready  = 1'b0;
    if_req_ready  = 1'b0;
    case (gnt)
      GNT_LOAD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ld_req_addr;
        ld_req_ready  = mem_req_ready;
      end
      GNT_STORE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = st_req_addr;
        mem_req_wdata = st_req_wdata;
        mem_req_wstrb = st_req_wstrb;
        st_req_ready  = mem_req_ready;
      end
      GNT_FETCH: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = if_req_addr;
        if_req_ready  = mem_req_ready;
      end
      default: ;
    endcase
  end

  assign if_hs     = if_req_valid && if_req_ready;
  assign fifo_push = mem_req_valid && mem_req_ready && (gnt == GNT_LOAD || gnt == GNT_FETCH);

  always_comb begin
    push_entry      = '0;
    push_entry.src  = (gnt == GNT_LOAD) ? SRC_LOAD : SRC_FETCH;
    push_entry.tag  = (gnt == GNT_LOAD) ? LDTAG_MAX_W'(ld_req_tag) : '0;
    push_entry.drop = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || if_hs)           starve_d = '0;
    else if (starve_q != SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  rd_order_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_rd_order_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .flush_i      (if_flush && !rst),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  // Responses follow the FIFO head; a dropped fetch is drained without being presented.
  always_comb begin
    mem_resp_ready = 1'b0;
    ld_resp_valid  = 1'b0;
    ld_resp_data   = '0;
    ld_resp_tag    = '0;
    if_resp_valid  = 1'b0;
    if_resp_inst   = '0;
    if (!rst && !fifo_empty) begin
      if (head.drop) begin
        mem_resp_ready = 1'b1;
      end else if (head.src == SRC_LOAD) begin
        ld_resp_valid  = mem_resp_valid;
        ld_resp_data   = mem_resp_data;
        ld_resp_tag    = head.tag[LDTAG_W-1:0];
        mem_resp_ready = ld_resp_ready;
      end else begin
        if_resp_valid  = mem_resp_valid;
        if_resp_inst   = mem_resp_data;
        mem_resp_ready = if_resp_ready;
      end
    end
  end

  assign fifo_pop        = mem_resp_valid && mem_resp_ready;
  assign unused_tag_bits = ^head.tag;

  a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
    !(mem_resp_valid && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_flush;
  logic [31:0] if_req_addr, if_resp_inst;
  logic        ld_req_valid, ld_req_ready, ld_resp_valid, ld_resp_ready;
  logic [31:0] ld_req_addr, ld_resp_data;
  logic [3:0]  ld_req_tag, ld_resp_tag;
  logic        st_req_valid, st_req_ready;
  logic [31:0] st_req_addr, st_req_wdata;
  logic [3:0]  st_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_inst(if_resp_inst),
    .if_flush(if_flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_tag(ld_req_tag), .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready),
    .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
    .st_req_wdata(st_req_wdata), .st_req_wstrb(st_req_wstrb),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } req_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } ldr_t;

  req_t        exp_req_q[$];
  ldr_t        exp_ld_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] rdata_q[$];
  int          pending = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  int          base_cyc = 0;
  bit          rd_hs = 0;
  bit          resp_hs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t rd_req(input logic [31:0] a, input int c);
    req_t r;
    r.we = 1'b0; r.addr = a; r.wdata = '0; r.wstrb = '0; r.cyc = c;
    return r;
  endfunction

  function automatic ldr_t ld_rsp(input logic [3:0] t, input logic [31:0] d);
    ldr_t r;
    r.tag = t; r.data = d;
    return r;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compares each DUT handshake against the head of the matching expectation queue.
  always @(negedge clk) begin
    req_t e;
    ldr_t l;
    logic [31:0] i;
    rd_hs   = 1'b0;
    resp_hs = 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      check("onehot_req_ready", 64'($countones({ld_req_ready, st_req_ready, if_req_ready})), 64'd1);
      if (exp_req_q.size() == 0) check("unexpected_mem_req", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_req_q.pop_front();
        if (e.we) check("mem_req_store", {27'd0, mem_req_we, mem_req_addr, mem_req_wstrb},
                        {27'd0, e.we, e.addr, e.wstrb});
        else      check("mem_req_read", {31'd0, mem_req_we, mem_req_addr}, {31'd0, e.we, e.addr});
        if (e.we) check("mem_req_wdata", 64'(mem_req_wdata), 64'(e.wdata));
        if (e.cyc >= 0) check("mem_req_cycle", 64'(cyc_cnt - base_cyc), 64'(e.cyc));
      end
      if (!mem_req_we) rd_hs = 1'b1;
    end
    if (ld_resp_valid && ld_resp_ready) begin
      if (exp_ld_q.size() == 0) check("unexpected_ld_resp", 64'(ld_resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        l = exp_ld_q.pop_front();
        check("ld_resp", {28'd0, ld_resp_tag, ld_resp_data}, {28'd0, l.tag, l.data});
      end
    end
    if (if_resp_valid && if_resp_ready) begin
      if (exp_if_q.size() == 0) check("unexpected_if_resp", 64'(if_resp_inst), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        i = exp_if_q.pop_front();
        check("if_resp", 64'(if_resp_inst), 64'(i));
      end
    end
    if (mem_resp_valid && mem_resp_ready) resp_hs = 1'b1;
  end

  // Memory model: one in-order response per read, data supplied by the test in rdata_q.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pending = 0;
        rdata_q.delete();
      end else begin
        if (resp_hs) begin
          void'(rdata_q.pop_front());
          pending--;
        end
        if (rd_hs) pending++;
      end
      mem_resp_valid = (pending > 0) && (rdata_q.size() > 0);
      mem_resp_data  = mem_resp_valid ? rdata_q[0] : 32'h0;
    end
  end

  task automatic send_ld(input logic [31:0] a, input logic [3:0] t);
    bit done = 0;
    ld_req_valid = 1'b1; ld_req_addr = a; ld_req_tag = t;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); done = ld_req_ready;
      @(posedge clk); #1;
    end
    ld_req_valid = 1'b0;
    if (!done) check("ld_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    st_req_valid = 1'b1; st_req_addr = a; st_req_wdata = d; st_req_wstrb = s;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); done = st_req_ready;
      @(posedge clk); #1;
    end
    st_req_valid = 1'b0;
    if (!done) check("st_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_if(input logic [31:0] a);
    bit done = 0;
    if_req_valid = 1'b1; if_req_addr = a;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); done = if_req_ready;
      @(posedge clk); #1;
    end
    if_req_valid = 1'b0;
    if (!done) check("if_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {57'd0, ld_req_ready, st_req_ready, if_req_ready, mem_req_valid,
                            mem_resp_ready, ld_resp_valid, if_resp_valid}, 64'd0);
    check({name, "_req_data"}, {27'd0, mem_req_we, mem_req_wstrb, mem_req_addr} | 64'(mem_req_wdata), 64'd0);
    check({name, "_resp_data"}, {28'd0, ld_resp_tag, ld_resp_data} | 64'(if_resp_inst), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h44; if_resp_ready = 1'b1; if_flush = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h55; ld_req_tag = 4'h3; ld_resp_ready = 1'b1;
    st_req_valid = 1'b1; st_req_addr = 32'h66; st_req_wdata = 32'h77; st_req_wstrb = 4'hF;
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; if_req_valid = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
    idle(2);

    // Contention: load, then store, then fetch on consecutive cycles.
    exp_req_q.push_back(rd_req(32'h10, 0));
    exp_req_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hCAFE_0001, wstrb: 4'h3, cyc: 1});
    exp_req_q.push_back(rd_req(32'h30, 2));
    rdata_q.push_back(32'h1111_0001); exp_ld_q.push_back(ld_rsp(4'h3, 32'h1111_0001));
    rdata_q.push_back(32'h2222_0002); exp_if_q.push_back(32'h2222_0002);
    base_cyc = cyc_cnt;
    fork
      send_ld(32'h10, 4'h3);
      send_st(32'h20, 32'hCAFE_0001, 4'h3);
      send_if(32'h30);
    join
    idle(4);

    // Starvation: fetch wins on the 9th cycle of continuous loads.
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        exp_req_q.push_back(rd_req(32'h500, 8));
        rdata_q.push_back(32'h0000_0500); exp_if_q.push_back(32'h0000_0500);
      end
      exp_req_q.push_back(rd_req(32'h1000 + 32'(k * 4), (k < 8) ? k : k + 1));
      rdata_q.push_back(32'hA000_0000 + 32'(k));
      exp_ld_q.push_back(ld_rsp(4'(k), 32'hA000_0000 + 32'(k)));
    end
    base_cyc = cyc_cnt;
    fork
      for (int k = 0; k < 10; k++) send_ld(32'h1000 + 32'(k * 4), 4'(k));
      send_if(32'h500);
    join
    idle(4);

    // FIFO full: reads blocked, store still issued.
    for (int k = 0; k < 4; k++) begin
      exp_req_q.push_back(rd_req(32'h400 + 32'(k * 4), -1));
      send_ld(32'h400 + 32'(k * 4), 4'(k + 8));
    end
    exp_req_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, cyc: -1});
    ld_req_valid = 1'b1; ld_req_addr = 32'h480; ld_req_tag = 4'h9;
    if_req_valid = 1'b1; if_req_addr = 32'h484;
    st_req_valid = 1'b1; st_req_addr = 32'h100; st_req_wdata = 32'hDEAD_BEEF; st_req_wstrb = 4'hF;
    @(negedge clk);
    check("full_readies", {61'd0, ld_req_ready, if_req_ready, st_req_ready}, 64'b001);
    check("full_store_we", 64'(mem_req_we), 64'd1);
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    @(negedge clk);
    check("full_blocks_reads", {62'd0, mem_req_valid, ld_req_ready}, 64'd0);
    @(posedge clk); #1;
    ld_req_valid = 1'b0; if_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdata_q.push_back(32'hB000_0000 + 32'(k));
      exp_ld_q.push_back(ld_rsp(4'(k + 8), 32'hB000_0000 + 32'(k)));
    end
    idle(8);

    // Flush: two outstanding fetches are drained silently.
    exp_req_q.push_back(rd_req(32'h200, -1)); send_if(32'h200);
    exp_req_q.push_back(rd_req(32'h204, -1)); send_if(32'h204);
    if_flush = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h208;
    @(negedge clk);
    check("flush_blocks_fetch", {62'd0, if_req_ready, mem_req_valid}, 64'd0);
    @(posedge clk); #1;
    if_flush = 1'b0; if_req_valid = 1'b0;
    rdata_q.push_back(32'h0000_0013); rdata_q.push_back(32'h0000_0013);
    for (int k = 0; k < 2; k++) begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = mem_resp_valid;
        if (!seen) begin @(posedge clk); #1; end
      end
      if (!seen) check("flush_resp_timeout", 64'd0, 64'd1);
      else check("flush_drop", {62'd0, if_resp_valid, mem_resp_ready}, 64'b01);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("flush_fifo_empty", {62'd0, mem_resp_valid, mem_resp_ready}, 64'd0);
    @(posedge clk); #1;

    // Backpressure on the load response port.
    ld_resp_ready = 1'b0;
    exp_req_q.push_back(rd_req(32'h300, -1));
    rdata_q.push_back(32'h1234_5678);
    exp_ld_q.push_back(ld_rsp(4'h5, 32'h1234_5678));
    send_ld(32'h300, 4'h5);
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", {62'd0, ld_resp_valid, mem_resp_ready}, 64'b10);
      @(posedge clk); #1;
    end
    ld_resp_ready = 1'b1;
    idle(3);

    // Reset with three loads outstanding.
    for (int k = 0; k < 3; k++) begin
      exp_req_q.push_back(rd_req(32'h600 + 32'(k * 4), -1));
      send_ld(32'h600 + 32'(k * 4), 4'(k));
    end
    rst = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h777;
    st_req_valid = 1'b1; st_req_addr = 32'h778;
    @(negedge clk);
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
    @(negedge clk);
    check("post_reset_empty", {62'd0, mem_resp_ready, mem_req_valid}, 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp_req_q.push_back(rd_req(32'h700 + 32'(k * 4), -1));
      send_ld(32'h700 + 32'(k * 4), 4'(k + 4));
    end
    for (int k = 0; k < 4; k++) begin
      rdata_q.push_back(32'hC000_0000 + 32'(k));
      exp_ld_q.push_back(ld_rsp(4'(k + 4), 32'hC000_0000 + 32'(k)));
    end
    idle(10);

    check("exp_req_drained", 64'(exp_req_q.size()), 64'd0);
    check("exp_ld_drained", 64'(exp_ld_q.size()), 64'd0);
    check("exp_if_drained", 64'(exp_if_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
